// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the memory responder: array depth
//                and derived address width, default wait-state count, and
//                the access state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Default number of 32-bit words in the array
    localparam int unsigned DEPTH_DEF = 512;

    // Default wait-state cycles per access (legal range 0..15)
    localparam int unsigned WAIT_DEF = 2;

    // Word-address width needed to index an array of the given depth
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned ADDR_W = addr_width(DEPTH_DEF);

    // Access state machine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ARM  = 2'd3
    } state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port DEPTH x 32 storage with synchronous write and
//                synchronous read. The read register only updates on a read
//                access, so it holds the last value read. Reset clears the
//                read register only; the storage contents are never
//                initialised.
//  Ports       : clk_i    - clock
//                rst_i    - asynchronous active-high reset (read register)
//                en_i     - access strobe
//                we_i     - 1 = write, 0 = read (qualified by en_i)
//                addr_i   - word address
//                wdata_i  - write data
//                rdata_o  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder
//  Description : Wait-stated word memory for a simple CPU datapath. A rising
//                edge on Read or Write (Read wins a tie) starts one access;
//                address, data and operation are latched, WAIT busy cycles
//                elapse, the array is accessed on the edge entering DONE and
//                MemDone pulses for that one cycle. The initiator must drop
//                both requests before the next access can start.
//  Ports       : Clock    - clock, rising edge
//                Clear    - asynchronous active-high reset
//                Read     - read request
//                Write    - write request
//                Address  - word address
//                DataIn   - write data
//                Mdatain  - read data (holds last read value)
//                MemBusy  - high whenever the FSM is not IDLE
//                MemDone  - one-cycle completion pulse
//                AddrErr  - out-of-range flag, pulses with MemDone
//  Options     : MEM_BOUNDS_CHECK_EN - when defined, accesses with
//                Address >= DEPTH flag AddrErr, suppress writes and return 0
//                on reads. When undefined, high address bits alias.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WAIT  = WAIT_DEF
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] Mdatain,
    output logic        MemBusy,
    output logic        MemDone,
    output logic        AddrErr
);

    localparam int unsigned AW       = addr_width(DEPTH);
    localparam bit          NO_WAIT  = (WAIT == 0);
    localparam logic [3:0]  CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            rd_hist_q;
    logic            wr_hist_q;
    logic            op_wr_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic            busy_q;
    logic            done_q;

    logic            rd_rise;
    logic            wr_rise;
    logic            accept;
    logic            acc_wr;
    logic [AW-1:0]   acc_addr;
    logic [31:0]     acc_data;
    logic            acc_oob;
    logic            enter_done;
    logic            arr_en;
    logic [31:0]     arr_rdata;

    assign rd_rise = Read  & ~rd_hist_q;
    assign wr_rise = Write & ~wr_hist_q;
    assign accept  = (state_q == IDLE) && (rd_rise || wr_rise);

    // With zero wait states the array is accessed on the accepting edge
    // itself, before the latches are loaded, so the live inputs are used in
    // IDLE and the latched copies otherwise.
    assign acc_wr   = (state_q == IDLE) ? ~rd_rise : op_wr_q;
    assign acc_addr = (state_q == IDLE) ? Address[AW-1:0] : addr_q;
    assign acc_data = (state_q == IDLE) ? DataIn : data_q;

    assign enter_done = !Clear &&
                        ((accept && NO_WAIT) ||
                         (state_q == BUSY && cnt_q == 4'd0));

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob_q;
    logic err_q;
    logic rdz_q;   // last completed read was out of range -> present 0

    assign acc_oob = (state_q == IDLE) ? (Address >= 32'(DEPTH)) : oob_q;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            oob_q <= 1'b0;
            err_q <= 1'b0;
            rdz_q <= 1'b0;
        end else begin
            if (accept) begin
                oob_q <= (Address >= 32'(DEPTH));
            end
            err_q <= enter_done && acc_oob;
            if (enter_done && !acc_wr) begin
                rdz_q <= acc_oob;
            end
        end
    end

    assign Mdatain = rdz_q ? 32'd0 : arr_rdata;
    assign AddrErr = err_q;
`else
    logic unused_addr_hi;

    assign acc_oob        = 1'b0;
    assign unused_addr_hi = ^Address[31:AW];
    assign Mdatain        = arr_rdata;
    assign AddrErr        = 1'b0;
`endif

    // Out-of-range accesses never touch the array: writes are dropped and
    // the read register keeps its previous contents.
    assign arr_en = enter_done && !acc_oob;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rd_hist_q <= 1'b0;
            wr_hist_q <= 1'b0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_hist_q <= Read;
            wr_hist_q <= Write;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_wr_q <= ~rd_rise;
                        addr_q  <= Address[AW-1:0];
                        data_q  <= DataIn;
                        busy_q  <= 1'b1;
                        if (NO_WAIT) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= ARM;
                end
                ARM: begin
                    // Re-arm only once the initiator has released both lines
                    if (!Read && !Write) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MemBusy = busy_q;
    assign MemDone = done_q;

    mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_array (
        .clk_i   (Clock),
        .rst_i   (Clear),
        .en_i    (arr_en),
        .we_i    (acc_wr),
        .addr_i  (acc_addr),
        .wdata_i (acc_data),
        .rdata_o (arr_rdata)
    );

endmodule : memory_responder
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Self-checking bench. Drives a WAIT=2 instance through a
//                cycle-accurate vector table plus directed sequences (held
//                request, read/write tie, Clear mid-access, address wrap or
//                bounds error), and a WAIT=0 instance through a write/read
//                pair. MEM_BOUNDS_CHECK_EN selects the out-of-range
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

    logic        clk;
    logic        Clear;

    logic        rd2, wr2;
    logic [31:0] addr2, din2, mdat2;
    logic        busy2, done2, err2;

    logic        rd0, wr0;
    logic [31:0] addr0, din0, mdat0;
    logic        busy0, done0, err0;

    int errors = 0;
    int checks = 0;

    memory_responder #(.DEPTH(512), .WAIT(2)) dut (
        .Clock   (clk),
        .Clear   (Clear),
        .Read    (rd2),
        .Write   (wr2),
        .Address (addr2),
        .DataIn  (din2),
        .Mdatain (mdat2),
        .MemBusy (busy2),
        .MemDone (done2),
        .AddrErr (err2)
    );

    memory_responder #(.DEPTH(512), .WAIT(0)) dut0 (
        .Clock   (clk),
        .Clear   (Clear),
        .Read    (rd0),
        .Write   (wr0),
        .Address (addr0),
        .DataIn  (din0),
        .Mdatain (mdat0),
        .MemBusy (busy0),
        .MemDone (done0),
        .AddrErr (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic        busy;
        logic        done;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One complete access on the selected instance (z=1 -> WAIT=0 instance).
    // Returns the cycle index (1 = first cycle after the accepting edge) at
    // which MemDone was seen, plus Mdatain/AddrErr in that cycle.
    task automatic access(input bit z, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] data,
                          output logic err);
        lat  = -1;
        data = 32'hx;
        err  = 1'bx;
        if (z) begin rd0 = r; wr0 = w; addr0 = a; din0 = d; end
        else   begin rd2 = r; wr2 = w; addr2 = a; din2 = d; end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (z ? done0 : done2) begin
                lat  = k;
                data = z ? mdat0 : mdat2;
                err  = z ? err0 : err2;
                break;
            end
        end
        if (z) begin rd0 = 1'b0; wr0 = 1'b0; end
        else   begin rd2 = 1'b0; wr2 = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          n;
        logic [31:0] data;
        logic        err;

        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h11, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h11, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        vecs[9] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF};

        Clear = 1'b1;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'h0; din2 = 32'h0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy2}, 32'd0);
        chk("reset done", {31'd0, done2}, 32'd0);
        chk("reset err",  {31'd0, err2},  32'd0);
        chk("reset data", mdat2, 32'd0);
        chk("reset busy w0", {31'd0, busy0}, 32'd0);
        chk("reset data w0", mdat0, 32'd0);
        Clear = 1'b0;

        // Write 0xDEADBEEF @0x10 then read it, cycle by cycle; address and
        // data are disturbed after acceptance.
        for (int i = 0; i < 10; i++) begin
            rd2 = vecs[i].rd; wr2 = vecs[i].wr;
            addr2 = vecs[i].addr; din2 = vecs[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d busy", i), {31'd0, busy2}, {31'd0, vecs[i].busy});
            chk($sformatf("vec%0d done", i), {31'd0, done2}, {31'd0, vecs[i].done});
            chk($sformatf("vec%0d err",  i), {31'd0, err2},  32'd0);
            chk($sformatf("vec%0d data", i), mdat2, vecs[i].data);
        end

        // Latency through the access task, write then read
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h2020_2020, lat, data, err);
        chk("wr latency", 32'(lat), 32'd3);
        chk("wr keeps Mdatain", data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, data, err);
        chk("rd latency", 32'(lat), 32'd3);
        chk("rd data 0x10", data, 32'hDEADBEEF);

        // Read held high for 10 cycles: exactly one completion
        rd2 = 1'b1; addr2 = 32'h20; n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done2) n++;
        end
        chk("held read busy", {31'd0, busy2}, 32'd1);
        rd2 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done2) n++;
        end
        chk("held read pulses", 32'(n), 32'd1);
        chk("held read data", mdat2, 32'h2020_2020);
        rd2 = 1'b1; n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done2) n++;
        end
        rd2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("re-raised read pulses", 32'(n), 32'd1);

        // Read and Write rise together: read wins, write dropped
        access(1'b0, 1'b0, 1'b1, 32'h30, 32'h1, lat, data, err);
        access(1'b0, 1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, lat, data, err);
        chk("tie read data", data, 32'h1);
        access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, data, err);
        chk("tie write dropped", data, 32'h1);

        // Clear in the second BUSY cycle of a write aborts it
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A5_0040, lat, data, err);
        rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'h40; din2 = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-clear busy", {31'd0, busy2}, 32'd1);
        Clear = 1'b1;
        #1;
        chk("clear busy", {31'd0, busy2}, 32'd0);
        chk("clear done", {31'd0, done2}, 32'd0);
        chk("clear err",  {31'd0, err2},  32'd0);
        chk("clear data", mdat2, 32'd0);
        @(posedge clk);
        #1;
        wr2 = 1'b0; Clear = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, data, err);
        chk("aborted write", data, 32'hA5A5_0040);

        // Address 0x200 on a 512-word array
        access(1'b0, 1'b0, 1'b1, 32'h000, 32'h0BAD_F00D, lat, data, err);
        access(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, lat, data, err);
        chk("oob latency", 32'(lat), 32'd3);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("oob err", {31'd0, err}, 32'd1);
        chk("oob data", data, 32'd0);
        chk("oob err clears", {31'd0, err2}, 32'd0);
        chk("oob data holds", mdat2, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, data, err);
        chk("post-oob read", data, 32'hDEADBEEF);
        chk("post-oob err", {31'd0, err}, 32'd0);
`else
        chk("wrap err", {31'd0, err}, 32'd0);
        chk("wrap data", data, 32'h0BAD_F00D);
`endif

        // Zero-wait instance
        access(1'b1, 1'b0, 1'b1, 32'h5, 32'h1234_5678, lat, data, err);
        chk("w0 wr latency", 32'(lat), 32'd1);
        chk("w0 wr keeps data", data, 32'd0);
        access(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, lat, data, err);
        chk("w0 rd latency", 32'(lat), 32'd1);
        chk("w0 rd data", data, 32'h1234_5678);
        chk("w0 idle busy", {31'd0, busy0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_memory_responder
`default_nettype wire
